// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: shared constants for the Wishbone GPIO controller.
// Register word addresses, pin direction encoding and the arm-counter
// terminal value used to mask edge events while the input pipeline fills.
package wb_gpio_pkg;

    // Register word addresses (compared against the zero-extended adr_i)
    localparam logic [31:0] ADDR_DATA_IN    = 32'd0;
    localparam logic [31:0] ADDR_DATA_OUT   = 32'd1;
    localparam logic [31:0] ADDR_DIR        = 32'd2;
    localparam logic [31:0] ADDR_RISE_EN    = 32'd3;
    localparam logic [31:0] ADDR_FALL_EN    = 32'd4;
    localparam logic [31:0] ADDR_IRQ_STATUS = 32'd5;
    localparam logic [31:0] ADDR_SET        = 32'd6;
    localparam logic [31:0] ADDR_CLR        = 32'd7;

    // DIR bit encoding: 1 drives the pad, 0 leaves it as an input
    localparam logic DIR_INPUT  = 1'b0;
    localparam logic DIR_OUTPUT = 1'b1;

    // Edge events are accepted only once the arm counter reaches this value
    localparam logic [1:0] ARM_CNT_MAX = 2'd3;

endpackage : wb_gpio_pkg

// File: rtl/wb_gpio_ctrl_edge_det.sv
// gpio_edge_det: two-flop synchroniser for asynchronous pad inputs plus a
// history flop, producing the synchronised value and per-pin rise/fall
// strobes. Edges are produced for every pin regardless of direction.
module gpio_edge_det #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    // Synchroniser chain followed by the previous-value flop for edge compare
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= {WIDTH{1'b0}};
            r_sync2 <= {WIDTH{1'b0}};
            r_prev  <= {WIDTH{1'b0}};
        end else begin
            r_sync1 <= i_gpio;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_sync = r_sync2;
    assign o_rise = r_sync2 & ~r_prev;
    assign o_fall = ~r_sync2 & r_prev;

endmodule : gpio_edge_det

// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl: Wishbone-slave GPIO controller with per-pin direction,
// synchronised inputs, rise/fall edge interrupts with sticky W1C status and
// a single registered level interrupt.
// Optional feature macro: GPIO_SETCLR_EN adds write-only SET (addr 6) and
// CLR (addr 7) registers for atomic DATA_OUT bit manipulation.
module wb_gpio_ctrl
    import wb_gpio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [AW-1:0]    adr_i,
    input  logic [DW-1:0]    data_i,
    output logic [DW-1:0]    data_o,
    output logic             ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    logic             r_ack;
    logic [DW-1:0]    r_rdata;
    logic             r_irq;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [1:0]       r_arm_cnt;

    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_adr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_armed;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_val;

    // A request is only accepted while no ack is outstanding, so a held
    // strobe completes on alternate cycles.
    assign w_req   = cyc_i & stb_i & ~r_ack;
    assign w_wr    = w_req & we_i;
    assign w_rd    = w_req & ~we_i;
    assign w_adr   = 32'(adr_i);
    assign w_wdata = data_i[WIDTH-1:0];

    generate
        if (DW > WIDTH) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^data_i[DW-1:WIDTH];
        end
    endgenerate

    gpio_edge_det #(
        .WIDTH (WIDTH)
    ) u_edge_det (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_gpio  (gpio_i),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Arm counter: saturating count that holds off edge events until the
    // synchroniser and history flops carry real pad samples.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_arm_cnt <= 2'd0;
        end else if (r_arm_cnt != ARM_CNT_MAX) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
        end
    end

    assign w_armed = (r_arm_cnt == ARM_CNT_MAX);
    assign w_event = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en))
                             : {WIDTH{1'b0}};
    assign w_clr   = (w_wr && (w_adr == ADDR_IRQ_STATUS)) ? w_wdata
                                                          : {WIDTH{1'b0}};

    // Read mux over the current register contents; unmapped addresses read 0
    always_comb begin
        w_rd_val = {WIDTH{1'b0}};
        case (w_adr)
            ADDR_DATA_IN:    w_rd_val = w_sync;
            ADDR_DATA_OUT:   w_rd_val = r_data_out;
            ADDR_DIR:        w_rd_val = r_dir;
            ADDR_RISE_EN:    w_rd_val = r_rise_en;
            ADDR_FALL_EN:    w_rd_val = r_fall_en;
            ADDR_IRQ_STATUS: w_rd_val = r_status;
            default:         w_rd_val = {WIDTH{1'b0}};
        endcase
    end

    // Bus response: single-cycle ack, read data valid only alongside it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= {DW{1'b0}};
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? DW'(w_rd_val) : {DW{1'b0}};
        end
    end

    // Control registers, updated on the same edge that raises the ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data_out <= {WIDTH{1'b0}};
            r_dir      <= {WIDTH{DIR_INPUT}};
            r_rise_en  <= {WIDTH{1'b0}};
            r_fall_en  <= {WIDTH{1'b0}};
        end else if (w_wr) begin
            case (w_adr)
                ADDR_DATA_OUT: r_data_out <= w_wdata;
                ADDR_DIR:      r_dir      <= w_wdata;
                ADDR_RISE_EN:  r_rise_en  <= w_wdata;
                ADDR_FALL_EN:  r_fall_en  <= w_wdata;
`ifdef GPIO_SETCLR_EN
                ADDR_SET:      r_data_out <= r_data_out | w_wdata;
                ADDR_CLR:      r_data_out <= r_data_out & ~w_wdata;
`endif
                default:       r_data_out <= r_data_out;
            endcase
        end
    end

    // Sticky status: a new event in the same cycle as a clear keeps the bit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_status <= {WIDTH{1'b0}};
        end else begin
            r_status <= (r_status & ~w_clr) | w_event;
        end
    end

    // Combined level interrupt, one cycle behind the status register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_status;
        end
    end

    assign ack_o     = r_ack;
    assign data_o    = r_rdata;
    assign irq_o     = r_irq;
    assign gpio_o    = r_data_out;
    assign gpio_oe_o = r_dir;

endmodule : wb_gpio_ctrl

// File: tb/tb_wb_gpio_ctrl.sv
// Testbench for wb_gpio_ctrl: directed scenarios followed by randomized bus
// and pad activity, checked every cycle against a history-based model.
module tb_wb_gpio_ctrl;

    localparam int WIDTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [AW-1:0]    adr;
    logic [DW-1:0]    dat_w;
    logic [DW-1:0]    dat_r;
    logic             ack;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_gpio_ctrl #(
        .WIDTH (WIDTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .we_i      (we),
        .adr_i     (adr),
        .data_i    (dat_w),
        .data_o    (dat_r),
        .ack_o     (ack),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    // Reference model state. Pad history h holds the samples taken at the
    // last three clock edges (h[0] oldest); DATA_IN is the sample from two
    // edges ago and an edge is a change between that and the one before.
    logic        m_ack;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  m_dout, m_dir, m_ren, m_fen, m_stat;
    int          m_k;
    logic [7:0]  h[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ack   = 1'b0;
        m_irq   = 1'b0;
        m_rdata = 32'h0;
        m_dout  = 8'h00;
        m_dir   = 8'h00;
        m_ren   = 8'h00;
        m_fen   = 8'h00;
        m_stat  = 8'h00;
        m_k     = 0;
        h       = '{8'h00, 8'h00, 8'h00};
    endtask

    task automatic model_step();
        logic       req;
        logic [7:0] s2, pv, ev, clr, rd;
        logic       irq_n;
        req = cyc & stb & ~m_ack;
        if (m_k < 8) m_k++;
        s2 = h[1];
        pv = h[0];
        // first three edges after release carry reset-filled history
        ev = (m_k >= 4) ? ((s2 & ~pv & m_ren) | (~s2 & pv & m_fen)) : 8'h00;
        irq_n = (m_stat != 8'h00);
        rd  = 8'h00;
        clr = 8'h00;
        if (req && !we) begin
            case (int'(adr))
                0: rd = s2;
                1: rd = m_dout;
                2: rd = m_dir;
                3: rd = m_ren;
                4: rd = m_fen;
                5: rd = m_stat;
                default: rd = 8'h00;
            endcase
        end
        if (req && we) begin
            case (int'(adr))
                1: m_dout = dat_w[7:0];
                2: m_dir  = dat_w[7:0];
                3: m_ren  = dat_w[7:0];
                4: m_fen  = dat_w[7:0];
                5: clr    = dat_w[7:0];
`ifdef GPIO_SETCLR_EN
                6: m_dout = m_dout | dat_w[7:0];
                7: m_dout = m_dout & ~dat_w[7:0];
`endif
                default: clr = 8'h00;
            endcase
        end
        m_stat  = (m_stat & ~clr) | ev;
        m_ack   = req;
        m_rdata = {24'h0, rd};
        m_irq   = irq_n;
        h.push_back(gpio_in);
        void'(h.pop_front());
    endtask

    // One clock: advance the model at the edge, compare all outputs after it
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_eq("ack_o",     32'(ack),      32'(m_ack));
        check_eq("data_o",    dat_r,         m_rdata);
        check_eq("irq_o",     32'(irq),      32'(m_irq));
        check_eq("gpio_o",    32'(gpio_out), 32'(m_dout));
        check_eq("gpio_oe_o", 32'(gpio_oe),  32'(m_dir));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; dat_w = 32'h0;
        tick();
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_do;
        model_reset();
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = 32'h0; gpio_in = 8'hFF;

        // reset with all pads high, then let the pipeline settle
        ticks(3);
        rst_n = 1'b1;
        ticks(10);
        bus_read(3'd5, rd);
        check_eq("rst_status", rd, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        bus_read(3'd0, rd);
        check_eq("rst_data_in", rd, 32'hFF);
        check_eq("rst_oe", 32'(gpio_oe), 32'h0);

        // register write and readback
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd2; dat_w = 32'h0F;
        tick();
        check_eq("dir_at_ack", 32'(gpio_oe), 32'h0F);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat_w = 32'hA5;
        tick();
        check_eq("dout_at_ack", 32'(gpio_out), 32'hA5);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        bus_read(3'd2, rd);
        check_eq("dir_rb", rd, 32'h0F);
        bus_read(3'd1, rd);
        check_eq("dout_rb", rd, 32'hA5);

        // rising edge on pin 0, four cycles to irq; falling edge ignored
        gpio_in = 8'h00;
        ticks(4);
        bus_write(3'd3, 32'h01);
        bus_write(3'd4, 32'h00);
        gpio_in[0] = 1'b1;
        ticks(3);
        check_eq("rise_irq_early", 32'(irq), 32'h0);
        tick();
        check_eq("rise_irq", 32'(irq), 32'h1);
        gpio_in[0] = 1'b0;
        ticks(4);
        bus_read(3'd5, rd);
        check_eq("rise_status", rd, 32'h01);
        bus_write(3'd5, 32'h01);
        check_eq("rise_clr_irq", 32'(irq), 32'h0);

        // event on pin 2 coincides with a clear of pin 2: event wins
        bus_write(3'd3, 32'h04);
        gpio_in[2] = 1'b1;
        ticks(2);
        bus_write(3'd5, 32'h04);
        bus_read(3'd5, rd);
        check_eq("w1c_race", rd, 32'h04);
        bus_write(3'd5, 32'h04);
        check_eq("w1c_irq_drop", 32'(irq), 32'h0);
        bus_read(3'd5, rd);
        check_eq("w1c_cleared", rd, 32'h00);

        // reset asserted right after a read ack with irq pending
        bus_write(3'd3, 32'h02);
        gpio_in[1] = 1'b1;
        ticks(4);
        check_eq("pre_rst_irq", 32'(irq), 32'h1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd1;
        tick();
        check_eq("pre_rst_data", dat_r, 32'hA5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_ack", 32'(ack), 32'h0);
        check_eq("mid_rst_data", dat_r, 32'h0);
        check_eq("mid_rst_irq", 32'(irq), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        check_eq("post_rst_ack", 32'(ack), 32'h0);

        // SET/CLR registers (inert without the feature)
        bus_write(3'd1, 32'h0F);
        bus_write(3'd6, 32'h30);
        bus_write(3'd7, 32'h03);
        bus_read(3'd1, rd);
`ifdef GPIO_SETCLR_EN
        exp_do = 8'h3C;
`else
        exp_do = 8'h0F;
`endif
        check_eq("setclr", rd, 32'(exp_do));
        bus_read(3'd6, rd);
        check_eq("set_reads0", rd, 32'h0);

        // randomized bus traffic, held/aborted strobes and pad activity
        for (int i = 0; i < 3000; i++) begin
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            adr   = AW'($urandom_range(0, 7));
            dat_w = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 8'($urandom);
            tick();
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_gpio_ctrl
